// File: rtl/mips_stim_gen.sv
// mips_stim_gen: pseudo-random legal MIPS instruction generator that issues each
// instruction with a one-cycle pc_en strobe, waits the checker latency, samples
// op_done and scores the result.
//
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high
//   start      in   1   level; begins a run when idle or done
//   type_mask  in   7   class enables: [0]R [1]ADDI [2]LW [3]SW [4]BEQ [5]BNE [6]J
//   op_done    in   1   checker verdict, sampled only in CHECK
//   inst       out  32  instruction to CPU and checker
//   pc_en      out  1   issue strobe
//   busy       out  1   run in progress
//   done       out  1   run complete, held until next run or reset
//   pass_cnt   out  16  CHECKs that saw op_done=1 (saturating)
//   fail_cnt   out  16  CHECKs that saw op_done=0 (saturating)
//   fail_inst  out  32  first failing instruction of the run
module mips_stim_gen #(
    parameter int unsigned NUM_INST  = 256,
    parameter logic [31:0] SEED      = 32'hACE1_2357,
    parameter int unsigned CHECK_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  type_mask,
    input  logic        op_done,
    output logic [31:0] inst,
    output logic        pc_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [31:0] fail_inst
);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [15:0] LAST_INST = 16'(NUM_INST - 1);
    localparam logic [15:0] WAIT_LAST = 16'((CHECK_LAT >= 2) ? (CHECK_LAT - 2) : 0);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {IDLE, GEN, ISSUE, WAIT, CHECK, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] lfsr, lfsr_nxt, inst_nxt;
    logic [15:0] issued, wait_cnt;
    logic [7:0]  mask8;
    logic [2:0]  lo, cls;
    logic [4:0]  rd, rt1;
    logic [5:0]  funct;
    logic        run_start;

    always_ff @(posedge clk)
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        pc_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: state_nxt = (start && |type_mask) ? GEN : IDLE;
            GEN: begin
                busy      = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                pc_en     = 1'b1;
                state_nxt = (CHECK_LAT == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = (wait_cnt == WAIT_LAST) ? CHECK : WAIT;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = (issued == LAST_INST) ? DONE : GEN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = (start && |type_mask) ? GEN : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run_start = (state == IDLE || state == DONE) && state_nxt == GEN;

    // Galois right-shift form: feedback taps applied when bit 0 falls out.
    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);

    // Bit 7 of the widened mask is zero, so k==7 falls back like a disabled class.
    assign mask8 = {1'b0, type_mask};

    always_comb begin
        lo = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (type_mask[i]) lo = 3'(i);
    end

    assign cls = mask8[lfsr_nxt[2:0]] ? lfsr_nxt[2:0] : lo;
    assign rd  = (lfsr_nxt[15:11] == 5'd0) ? 5'd1 : lfsr_nxt[15:11];
    assign rt1 = (lfsr_nxt[20:16] == 5'd0) ? 5'd1 : lfsr_nxt[20:16];

    always_comb begin
        funct = FN_ADD;
        case (lfsr_nxt[28:26])
            3'd1:    funct = FN_SUB;
            3'd2:    funct = FN_AND;
            3'd3:    funct = FN_OR;
            3'd4:    funct = FN_NOR;
            3'd5:    funct = FN_SLT;
            3'd6:    funct = FN_XOR;
            default: funct = FN_ADD;
        endcase
    end

    always_comb begin
        inst_nxt = {OP_J, lfsr_nxt[25:0]};
        case (cls)
            3'd0: inst_nxt = {OP_R, lfsr_nxt[25:21], lfsr_nxt[20:16], rd, 5'd0, funct};
            3'd1: inst_nxt = {OP_ADDI, lfsr_nxt[25:21], rt1, lfsr_nxt[15:0]};
            3'd2: inst_nxt = {OP_LW, 5'd0, rt1, 9'd0, lfsr_nxt[6:2], 2'b00};
            3'd3: inst_nxt = {OP_SW, 5'd0, lfsr_nxt[20:16], 9'd0, lfsr_nxt[6:2], 2'b00};
            3'd4: inst_nxt = {OP_BEQ, lfsr_nxt[25:0]};
            3'd5: inst_nxt = {OP_BNE, lfsr_nxt[25:0]};
            default: inst_nxt = {OP_J, lfsr_nxt[25:0]};
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            lfsr      <= SEED;
            inst      <= 32'd0;
            pass_cnt  <= 16'd0;
            fail_cnt  <= 16'd0;
            fail_inst <= 32'd0;
            issued    <= 16'd0;
            wait_cnt  <= 16'd0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : 16'd0;
            if (run_start) begin
                pass_cnt  <= 16'd0;
                fail_cnt  <= 16'd0;
                fail_inst <= 32'd0;
                issued    <= 16'd0;
            end
            if (state == GEN) begin
                lfsr <= lfsr_nxt;
                inst <= inst_nxt;
            end
            if (state == CHECK) begin
                issued <= issued + 16'd1;
                if (op_done)
                    pass_cnt <= (pass_cnt == 16'hFFFF) ? pass_cnt : pass_cnt + 16'd1;
                else begin
                    fail_cnt <= (fail_cnt == 16'hFFFF) ? fail_cnt : fail_cnt + 16'd1;
                    if (fail_cnt == 16'd0) fail_inst <= inst;
                end
            end
        end
endmodule
